// File: rtl/spi_slave_tx_mlane.sv
// Multi-lane SPI slave transmit shifter with a small word FIFO.
// Words pushed over valid/ready are shifted out 1, 2 or 4 bits per sclk,
// MSB- or LSB-first. Consecutive words are sent without gaps, and a
// sticky underrun flag records a transfer that started with no data.
module spi_slave_tx_mlane #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  sclk,
  input  logic                  cs,
  input  logic [1:0]            lane_mode,
  input  logic                  lsb_first,
  input  logic [CNT_W-1:0]      counter_in,
  input  logic                  counter_in_upd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [3:0]            miso,
  output logic [3:0]            miso_oe,
  output logic                  done,
  output logic                  busy,
  output logic                  underrun
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]     fcount_q;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q, word_tgt_q, tgt_raw_q;
  logic [1:0]            lmode_q;   // 0 single, 1 dual, 2 quad
  logic                  underrun_q;

  logic                  fifo_full, fifo_empty, push, pop, load, end_of_word;
  logic [CNT_W-1:0]      next_raw;
  logic [1:0]            load_mode;
  logic [DATA_WIDTH-1:0] load_word;

  // Mode 11 behaves as single lane.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  // Clamp the requested beat target so a word never runs past its last bit.
  function automatic logic [CNT_W-1:0] clamp_tgt(input logic [CNT_W-1:0] t, input logic [1:0] m);
    logic [CNT_W-1:0] lim;
    case (m)
      2'b01:   lim = CNT_W'(DATA_WIDTH / 2 - 1);
      2'b10:   lim = CNT_W'(DATA_WIDTH / 4 - 1);
      default: lim = CNT_W'(DATA_WIDTH - 1);
    endcase
    return (t > lim) ? lim : t;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bitrev(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = x[DATA_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_next(input logic [DATA_WIDTH-1:0] s, input logic [1:0] m);
    case (m)
      2'b01:   return s << 2;
      2'b10:   return s << 4;
      default: return s << 1;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full   = (fcount_q == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fcount_q == '0);
  assign data_ready  = !fifo_full && !cs;
  assign push        = data_valid && data_ready;
  assign busy        = (state_q == S_SHIFT);
  assign end_of_word = busy && (cnt_q == word_tgt_q);
  assign done        = end_of_word;
  assign underrun    = underrun_q;
  // A target update arriving on the load edge itself applies to that load.
  assign next_raw    = counter_in_upd ? counter_in : tgt_raw_q;
  assign load        = !cs && (((state_q == S_IDLE) && counter_in_upd) ||
                               (end_of_word && !fifo_empty));
  assign pop         = load && !fifo_empty;
  assign load_mode   = norm_mode(lane_mode);

  // Select the word entering the shifter: FIFO head, or zeros on underrun.
  always_comb begin
    load_word = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    if (lsb_first) load_word = bitrev(load_word);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge sclk) begin
    if (push) fifo_q[wr_ptr_q] <= data;
  end

  // FIFO pointers and occupancy; cs flushes the buffer.
  always_ff @(posedge sclk) begin
    if (cs) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcount_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fcount_q <= fcount_q + 1'b1;
        2'b01:   fcount_q <= fcount_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Transfer FSM: load, shift, and chain the next word on the last beat.
  always_ff @(posedge sclk) begin
    if (cs) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tgt_raw_q  <= '1;
      word_tgt_q <= '1;
      lmode_q    <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      if (counter_in_upd) tgt_raw_q <= counter_in;
      if (load) begin
        state_q    <= S_SHIFT;
        shift_q    <= load_word;
        cnt_q      <= '0;
        word_tgt_q <= clamp_tgt(next_raw, load_mode);
        lmode_q    <= load_mode;
        if (fifo_empty) underrun_q <= 1'b1;
      end else if (end_of_word) begin
        state_q <= S_IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (busy) begin
        cnt_q   <= cnt_q + 1'b1;
        shift_q <= shift_next(shift_q, lmode_q);
      end
    end
  end

  // Lane drive: top LANES shifter bits, highest bit on the highest lane.
  always_comb begin
    miso    = '0;
    miso_oe = '0;
    if (busy) begin
      case (lmode_q)
        2'b01: begin
          miso[1:0] = shift_q[DATA_WIDTH-1 -: 2];
          miso_oe   = 4'b0011;
        end
        2'b10: begin
          miso      = shift_q[DATA_WIDTH-1 -: 4];
          miso_oe   = 4'b1111;
        end
        default: begin
          miso[0]   = shift_q[DATA_WIDTH-1];
          miso_oe   = 4'b0001;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_tx_mlane.sv
// Self-checking bench for spi_slave_tx_mlane: directed scenarios plus
// randomized streams checked against a word-level beat model.
module tb_spi_slave_tx_mlane;

  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic [1:0]  lane_mode = 2'b00;
  logic        lsb_first = 1'b0;
  logic [4:0]  counter_in = '0;
  logic        counter_in_upd = 1'b0;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [3:0]  miso, miso_oe;
  logic        done, busy, underrun;

  int checks = 0;
  int failures = 0;
  bit exp_ur = 1'b0;
  logic [31:0] wq[$];

  always #5 sclk = ~sclk;

  spi_slave_tx_mlane dut (
    .sclk(sclk), .cs(cs), .lane_mode(lane_mode), .lsb_first(lsb_first),
    .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .miso(miso), .miso_oe(miso_oe), .done(done), .busy(busy), .underrun(underrun)
  );

  function automatic int lanes_of(input logic [1:0] m);
    return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
  endfunction

  // Beat b carries the b-th L-bit chunk counted from the top of the
  // (possibly bit-reversed) word; lane k gets the k-th bit of that chunk.
  function automatic logic [3:0] exp_lanes(input logic [31:0] w, input int L, input bit lsbf, input int b);
    logic [31:0] x;
    logic [3:0]  r;
    r = '0;
    for (int i = 0; i < 32; i++) x[i] = lsbf ? w[31-i] : w[i];
    for (int k = 0; k < L; k++) r[k] = x[32 - L*(b+1) + k];
    return r;
  endfunction

  // Stream wq (or one underrun word if wq is empty) and check every beat.
  // abort_beat > 0 raises cs after that many beats and checks the flush.
  task automatic run_stream(input string nm, input logic [1:0] mode, input bit lsbf,
                            input int tgt, input int abort_beat);
    int L, lim, nb, nw, pushed, wi, b;
    bit ur;
    logic [31:0] w;
    logic [3:0] oe;
    L   = lanes_of(mode);
    lim = 32 / L - 1;
    nb  = ((tgt > lim) ? lim : tgt) + 1;
    ur  = (wq.size() == 0);
    nw  = ur ? 1 : wq.size();
    oe  = 4'((1 << L) - 1);
    pushed = 0;
    @(negedge sclk);
    lane_mode = mode;
    lsb_first = lsbf;
    while (pushed < wq.size() && pushed < 2) begin
      checks++;
      if (data_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s prepush_ready: got %b expected 1", nm, data_ready);
      end
      data = wq[pushed];
      data_valid = 1'b1;
      pushed++;
      @(negedge sclk);
    end
    data_valid = 1'b0;
    counter_in = 5'(tgt);
    counter_in_upd = 1'b1;
    @(negedge sclk);
    counter_in_upd = 1'b0;
    if (ur) exp_ur = 1'b1;
    for (int g = 0; g < nw * nb; g++) begin
      wi = g / nb;
      b  = g % nb;
      w  = ur ? 32'h0 : wq[wi];
      checks++;
      if (miso !== exp_lanes(w, L, lsbf, b)) begin
        failures++;
        $display("FAIL %s miso word%0d beat%0d: got %h expected %h", nm, wi, b+1, miso, exp_lanes(w, L, lsbf, b));
      end
      checks++;
      if (miso_oe !== oe) begin
        failures++;
        $display("FAIL %s miso_oe beat%0d: got %b expected %b", nm, g+1, miso_oe, oe);
      end
      checks++;
      if (done !== (b == nb - 1)) begin
        failures++;
        $display("FAIL %s done beat%0d: got %b expected %b", nm, g+1, done, (b == nb - 1));
      end
      checks++;
      if (busy !== 1'b1 || underrun !== exp_ur) begin
        failures++;
        $display("FAIL %s busy/underrun beat%0d: got %b/%b expected 1/%b", nm, g+1, busy, underrun, exp_ur);
      end
      if (abort_beat > 0 && g == abort_beat - 1) begin
        cs = 1'b1;
        data_valid = 1'b0;
        @(negedge sclk);
        checks++;
        if (miso !== 4'h0 || miso_oe !== 4'h0 || busy !== 1'b0 || done !== 1'b0 ||
            data_ready !== 1'b0 || underrun !== 1'b0) begin
          failures++;
          $display("FAIL %s abort: got miso=%h oe=%h busy=%b done=%b rdy=%b ur=%b expected all 0",
                   nm, miso, miso_oe, busy, done, data_ready, underrun);
        end
        cs = 1'b0;
        exp_ur = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s ready_after_cs: got %b expected 1", nm, data_ready);
        end
        return;
      end
      if (pushed < wq.size() && data_ready === 1'b1) begin
        data = wq[pushed];
        data_valid = 1'b1;
        pushed++;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge sclk);
    end
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || miso !== 4'h0 || miso_oe !== 4'h0) begin
      failures++;
      $display("FAIL %s idle_after: got busy=%b done=%b miso=%h oe=%h expected 0", nm, busy, done, miso, miso_oe);
    end
    checks++;
    if (underrun !== exp_ur) begin
      failures++;
      $display("FAIL %s underrun_after: got %b expected %b", nm, underrun, exp_ur);
    end
  endtask

  task automatic test_reset();
    cs = 1'b1;
    repeat (2) @(negedge sclk);
    checks++;
    if (miso !== 4'h0 || miso_oe !== 4'h0 || done !== 1'b0 || busy !== 1'b0 ||
        underrun !== 1'b0 || data_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset: got miso=%h oe=%h done=%b busy=%b ur=%b rdy=%b expected all 0",
               miso, miso_oe, done, busy, underrun, data_ready);
    end
    cs = 1'b0;
    exp_ur = 1'b0;
    #1;
    checks++;
    if (data_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", data_ready);
    end
  endtask

  task automatic test_single_msb();
    wq = {32'hA500_0001};
    run_stream("single_msb", 2'b00, 1'b0, 31, 0);
  endtask

  task automatic test_quad();
    wq = {32'h1234_5678};
    run_stream("quad", 2'b10, 1'b0, 7, 0);
  endtask

  task automatic test_back_to_back();
    wq = {32'h1111_1111, 32'h2222_2222};
    run_stream("back_to_back", 2'b10, 1'b0, 7, 0);
  endtask

  task automatic test_underrun();
    wq.delete();
    run_stream("underrun", 2'b00, 1'b0, 3, 0);
    wq = {32'hDEAD_BEEF};
    run_stream("underrun_sticky", 2'b01, 1'b0, 15, 0);
  endtask

  task automatic test_lsb_first();
    wq = {32'h0000_0001};
    run_stream("lsb_first", 2'b00, 1'b1, 31, 0);
  endtask

  task automatic test_cs_abort();
    wq = {32'hCAFE_F00D, 32'h0BAD_1DEA};
    run_stream("cs_abort", 2'b01, 1'b0, 15, 5);
    wq.delete();
    run_stream("post_flush", 2'b00, 1'b0, 3, 0);
    test_reset();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 10; it++) begin
      n = int'($urandom_range(1, 4));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_stream("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_quad();
    test_back_to_back();
    test_underrun();
    test_lsb_first();
    test_cs_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
